mac_sequencer: RTL and testbench

//  Sequences one shared sign-magnitude fixed-point multiplier (1 sign bit, N-1 fractional bits)

---
 rtl/mac_sequencer_if.sv | 26 ++
 rtl/mac_sequencer.sv | 116 +++++++++++
 tb/tb_mac_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sequencer_if.sv
// Handshake bundle for mac_sequencer: pair stream in, multiplier operands/product,
// result handshake and status. slave = sequencer side, master = environment side.
interface mac_sequencer_if #(parameter int N = 16);
   logic         start;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_a;
   logic [N-1:0] in_w;
   logic [N-1:0] mul_a;
   logic [N-1:0] mul_w;
   logic [N-1:0] mul_p;
   logic         res_valid;
   logic         res_ready;
   logic [N-1:0] res;
   logic         busy;

   modport master (
      output start, in_valid, in_a, in_w, mul_p, res_ready,
      input  in_ready, mul_a, mul_w, res_valid, res, busy
   );

   modport slave (
      input  start, in_valid, in_a, in_w, mul_p, res_ready,
      output in_ready, mul_a, mul_w, res_valid, res, busy
   );
endinterface

// File: rtl/mac_sequencer.sv
// Time-multiplexes one external sign-magnitude multiplier over K pairs and
// accumulates the products in two's complement; result is saturated back to sign-magnitude.
module mac_sequencer #(
   parameter int N     = 16,
   parameter int K     = 4,
   parameter int ACC_W = N + $clog2(K)
) (
   input logic             clk,
   input logic             rst_n,
   mac_sequencer_if.slave  bus
);

   localparam int CNT_W = $clog2(K);
   localparam logic [ACC_W-1:0] MAX_MAG = {{(ACC_W-N+1){1'b0}}, {(N-1){1'b1}}};

   typedef enum logic [2:0] {IDLE, FETCH, MUL, ACC, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc;
   logic [N-1:0]     prod_q;
   logic [N-1:0]     mul_a_q;
   logic [N-1:0]     mul_w_q;
   logic             in_ready_q;
   logic             res_valid_q;
   logic             busy_q;

   logic [ACC_W-1:0] prod_mag;
   logic [ACC_W-1:0] prod_tc;
   logic             acc_neg;
   logic [ACC_W-1:0] acc_mag;
   logic [N-1:0]     res_c;

   // Negative zero from the multiplier becomes 0 - 0 = +0 here.
   always_comb begin
      prod_mag = {{(ACC_W-N+1){1'b0}}, prod_q[N-2:0]};
      prod_tc  = prod_q[N-1] ? (ACC_W'(0) - prod_mag) : prod_mag;
   end

   always_comb begin
      acc_neg = acc[ACC_W-1];
      acc_mag = acc_neg ? (ACC_W'(0) - acc) : acc;
      res_c   = {acc_neg, (acc_mag > MAX_MAG) ? {(N-1){1'b1}} : acc_mag[N-2:0]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         prod_q      <= '0;
         mul_a_q     <= '0;
         mul_w_q     <= '0;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc        <= '0;
                  cnt        <= '0;
                  state      <= FETCH;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            FETCH: begin
               if (bus.in_valid) begin
                  mul_a_q    <= bus.in_a;
                  mul_w_q    <= bus.in_w;
                  state      <= MUL;
                  in_ready_q <= 1'b0;
               end
            end
            MUL: begin
               prod_q <= bus.mul_p;
               state  <= ACC;
            end
            ACC: begin
               acc <= acc + prod_tc;
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(K-1)) begin
                  state       <= DONE;
                  res_valid_q <= 1'b1;
               end else begin
                  state      <= FETCH;
                  in_ready_q <= 1'b1;
               end
            end
            DONE: begin
               // A start arriving with res_ready is dropped; it must be re-presented in IDLE.
               if (bus.res_ready) begin
                  state       <= IDLE;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state       <= IDLE;
               in_ready_q  <= 1'b0;
               res_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_w     = mul_w_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res       = res_c;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer (N=8, K=4) with a stub multiplier and a
// sum-then-saturate reference model checked whenever a result is presented.
module tb_mac_sequencer;

   localparam int N = 8;
   localparam int K = 4;

   logic clk;
   logic rst_n;
   mac_sequencer_if #(.N(N)) bus ();

   mac_sequencer #(.N(N), .K(K)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] exp_res = 8'h00;
   logic [7:0] pa [4];
   logic [7:0] pw [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub multiplier: weight magnitude 0x40 acts as unity gain.
   function automatic logic [7:0] stub(input logic [7:0] a, input logic [7:0] w);
      int m;
      m = (int'(a[6:0]) * int'(w[6:0])) >>> 6;
      if (m > 127) m = 127;
      return {a[7] ^ w[7], 7'(m)};
   endfunction

   function automatic logic [7:0] model(input logic [7:0] p [4]);
      int s = 0;
      for (int i = 0; i < 4; i++)
         s += p[i][7] ? -int'(p[i][6:0]) : int'(p[i][6:0]);
      if (s > 127)  return 8'h7F;
      if (s < -127) return 8'hFF;
      if (s < 0)    return {1'b1, 7'(-s)};
      return {1'b0, 7'(s)};
   endfunction

   assign bus.mul_p = stub(bus.mul_a, bus.mul_w);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   always @(negedge clk)
      if (rst_n && bus.res_valid) chk("model_res", bus.res, exp_res);

   task automatic chk_all_zero(input string nm);
      chk({nm, "_in_ready"}, bus.in_ready, 0);
      chk({nm, "_res_valid"}, bus.res_valid, 0);
      chk({nm, "_busy"}, bus.busy, 0);
      chk({nm, "_mul_a"}, bus.mul_a, 0);
      chk({nm, "_mul_w"}, bus.mul_w, 0);
      chk({nm, "_res"}, bus.res, 0);
   endtask

   // Edges counted from the start-sampling edge (edge 1) up to the one raising res_valid.
   task automatic run(input int stall_at, input int rst_at, output int edges, output bit aborted);
      logic [7:0] pr [4];
      int b;
      for (int i = 0; i < 4; i++) pr[i] = stub(pa[i], pw[i]);
      exp_res = model(pr);
      edges = 0;
      aborted = 1'b0;
      bus.start = 1'b1;
      @(posedge clk); #1; edges++;
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_a = pa[i];
         bus.in_w = pw[i];
         bus.in_valid = (i != stall_at);
         b = 0;
         forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            chk("busy_run", bus.busy, 1);
            @(posedge clk); #1; edges++;
            if (++b > 20) begin
               chk("in_ready_timeout", 0, 1);
               aborted = 1'b1;
               return;
            end
         end
         if (i == stall_at) begin
            for (int s = 0; s < 5; s++) begin
               chk("stall_in_ready", bus.in_ready, 1);
               if (s == 0) bus.start = 1'b1;
               @(posedge clk); #1; edges++;
               bus.start = 1'b0;
               @(negedge clk);
            end
            chk("stall_in_ready", bus.in_ready, 1);
            bus.in_valid = 1'b1;
         end
         chk("busy_run", bus.busy, 1);
         @(posedge clk); #1; edges++;
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk_all_zero("rst_mid");
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk_all_zero("rst_held");
            rst_n = 1'b1;
            aborted = 1'b1;
            return;
         end
      end
      bus.in_valid = 1'b0;
      b = 0;
      forever begin
         @(negedge clk);
         if (bus.res_valid) break;
         chk("busy_run", bus.busy, 1);
         @(posedge clk); #1; edges++;
         if (++b > 20) begin
            chk("res_valid_timeout", 0, 1);
            aborted = 1'b1;
            return;
         end
      end
   endtask

   // Entered at a negedge with res_valid high.
   task automatic consume(input int hold, input bit with_start);
      logic [7:0] r0;
      r0 = bus.res;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("hold_valid", bus.res_valid, 1);
         chk("hold_res", bus.res, r0);
      end
      bus.res_ready = 1'b1;
      bus.start = with_start;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk("after_take_valid", bus.res_valid, 0);
      chk("after_take_busy", bus.busy, 0);
      if (with_start) begin
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_rerun_busy", bus.busy, 0);
            chk("no_rerun_in_ready", bus.in_ready, 0);
         end
      end
   endtask

   task automatic simple(input string nm, input logic [7:0] lit);
      int e;
      bit ab;
      run(-1, -1, e, ab);
      if (!ab) begin
         chk({nm, "_lit"}, bus.res, lit);
         chk({nm, "_latency"}, e, 13);
         consume(0, 0);
      end
   endtask

   initial begin
      int e;
      bit ab;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_w = '0;
      bus.res_ready = 1'b0;
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      pa = '{8'h10, 8'h10, 8'h10, 8'h10}; pw = '{8'h40, 8'h40, 8'h40, 8'h40};
      simple("t1_sum", 8'h40);
      pa = '{8'h20, 8'hA0, 8'h05, 8'h85};
      simple("t2_cancel", 8'h00);
      pa = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
      simple("t3_sat_pos", 8'h7F);
      pa = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      simple("t3_sat_neg", 8'hFF);
      pa = '{8'h80, 8'h80, 8'h03, 8'h80};
      simple("neg_zero", 8'h03);
      pa = '{8'h40, 8'h3F, 8'h00, 8'h00};
      simple("edge_127", 8'h7F);
      pa = '{8'h40, 8'h40, 8'h00, 8'h00};
      simple("edge_128", 8'h7F);
      pa = '{8'h85, 8'h83, 8'h01, 8'h00};
      simple("neg_7", 8'h87);
      pa = '{8'hC0, 8'hC0, 8'h00, 8'h00};
      simple("neg_128", 8'hFF);

      // Stall before pair 2 with a stray start pulse; 0x30*0x20 -> 0x18, total 24+16-5-2.
      pa = '{8'h30, 8'h10, 8'h85, 8'h02}; pw = '{8'h20, 8'h40, 8'h40, 8'hC0};
      run(1, -1, e, ab);
      if (!ab) begin
         chk("t4_lit", bus.res, 8'h21);
         chk("t4_latency", e, 18);
         consume(0, 0);
      end

      pa = '{8'h11, 8'h22, 8'h33, 8'h44}; pw = '{8'h40, 8'h40, 8'h40, 8'h40};
      run(-1, 2, e, ab);
      @(posedge clk); #1;
      chk_all_zero("post_rst");
      pa = '{8'h01, 8'h02, 8'h03, 8'h04};
      simple("t5_fresh", 8'h0A);

      pa = '{8'h40, 8'h3F, 8'h00, 8'h00};
      run(-1, -1, e, ab);
      if (!ab) begin
         chk("t6_lit", bus.res, 8'h7F);
         consume(10, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
